// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard and sequencing controller for the 5-stage RISC-V pipeline.
// Drives enable/flush of the PC register and the IF/ID, ID/EX, EX/MEM stage registers.
// Handles load-use stalls, taken-branch/jump redirect bubbles and data-memory wait freezes.
// Optional feature macro: PIPE_PERF_COUNTERS_EN (live performance counters when defined,
// both counter ports tied to 0 otherwise).
module pipeline_ctrl #(
  parameter int REDIRECT_BUBBLES = 2,
  parameter int CNT_W            = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  output logic             ena_pc,
  output logic             pc_sel_redirect,
  output logic             ena_ifid,
  output logic             flush_ifid,
  output logic             ena_idex,
  output logic             flush_idex,
  output logic             ena_exmem,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  // Bubble count loaded on a redirect: the entry cycle is the first flushed IF/ID cycle.
  localparam logic [2:0] BCNT_LOAD   = 3'(REDIRECT_BUBBLES - 1);
  localparam bit         MULTI_BUBBLE = (REDIRECT_BUBBLES > 1);

  state_t     state_r;
  state_t     ret_r;
  logic [2:0] bcnt_r;
  state_t     eff_state_s;
  logic       load_use_s;

  // While frozen, act as the state held before the freeze once memory is ready again.
  always_comb begin
    eff_state_s = ST_RUN;
    case (state_r)
      ST_RUN:      eff_state_s = ST_RUN;
      ST_REDIRECT: eff_state_s = ST_REDIRECT;
      ST_MEM_WAIT: eff_state_s = (ret_r == ST_REDIRECT) ? ST_REDIRECT : ST_RUN;
      default:     eff_state_s = ST_RUN;
    endcase
  end

  // Load-use hazard: a load in EX writes a register the ID instruction reads (x0 excluded).
  assign load_use_s = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

  // Stage enable/flush decode; priority is reset > mem_busy > redirect > bubbles > load-use.
  always_comb begin
    ena_pc          = 1'b1;
    pc_sel_redirect = 1'b0;
    ena_ifid        = 1'b1;
    flush_ifid      = 1'b0;
    ena_idex        = 1'b1;
    flush_idex      = 1'b0;
    ena_exmem       = 1'b1;
    if (!rst_n) begin
      ena_pc     = 1'b0;
      ena_ifid   = 1'b0;
      ena_idex   = 1'b0;
      ena_exmem  = 1'b0;
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
    end else if (mem_busy) begin
      ena_pc    = 1'b0;
      ena_ifid  = 1'b0;
      ena_idex  = 1'b0;
      ena_exmem = 1'b0;
    end else if (ex_redirect) begin
      pc_sel_redirect = 1'b1;
      flush_ifid      = 1'b1;
      flush_idex      = 1'b1;
    end else if (eff_state_s == ST_REDIRECT) begin
      flush_ifid = 1'b1;
    end else if (load_use_s) begin
      ena_pc     = 1'b0;
      ena_ifid   = 1'b0;
      flush_idex = 1'b1;
    end else begin
      ena_pc = 1'b1;
    end
  end

  // Sequencing state: freeze tracking, redirect bubble countdown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_RUN;
      ret_r   <= ST_RUN;
      bcnt_r  <= 3'd0;
    end else if (mem_busy) begin
      state_r <= ST_MEM_WAIT;
      if (state_r != ST_MEM_WAIT) begin
        ret_r <= eff_state_s;
      end else begin
        ret_r <= ret_r;
      end
    end else if (ex_redirect) begin
      if (MULTI_BUBBLE) begin
        state_r <= ST_REDIRECT;
        bcnt_r  <= BCNT_LOAD;
      end else begin
        state_r <= ST_RUN;
        bcnt_r  <= 3'd0;
      end
    end else if (eff_state_s == ST_REDIRECT) begin
      if (bcnt_r <= 3'd1) begin
        state_r <= ST_RUN;
        bcnt_r  <= 3'd0;
      end else begin
        state_r <= ST_REDIRECT;
        bcnt_r  <= bcnt_r - 3'd1;
      end
    end else begin
      state_r <= ST_RUN;
      bcnt_r  <= 3'd0;
    end
  end

`ifdef PIPE_PERF_COUNTERS_EN
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  // Performance counters: stall = any cycle the PC is held, flush = redirect entry cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_r <= stall_cnt_r + (ena_pc ? {CNT_W{1'b0}} : CNT_W'(1));
      flush_cnt_r <= flush_cnt_r + (pc_sel_redirect ? CNT_W'(1) : {CNT_W{1'b0}});
    end
  end

  assign perf_stall_cnt = stall_cnt_r;
  assign perf_flush_cnt = flush_cnt_r;
`else
  assign perf_stall_cnt = {CNT_W{1'b0}};
  assign perf_flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed vector table plus randomized
// stimulus against a cycle-level reference model of the hazard rules.
module tb_pipeline_ctrl;

  localparam int B     = 2;
  localparam int CNT_W = 32;

  // Expected control pattern: {ena_pc, pc_sel_redirect, ena_ifid, flush_ifid, ena_idex, flush_idex, ena_exmem}
  localparam logic [6:0] P_RUN    = 7'b1010101;
  localparam logic [6:0] P_STALL  = 7'b0000111;
  localparam logic [6:0] P_ENTRY  = 7'b1111111;
  localparam logic [6:0] P_BUBBLE = 7'b1011101;
  localparam logic [6:0] P_FROZEN = 7'b0000000;
  localparam logic [6:0] P_RESET  = 7'b0001010;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect, mem_busy;
  logic ena_pc, pc_sel_redirect, ena_ifid, flush_ifid, ena_idex, flush_idex, ena_exmem;
  logic [CNT_W-1:0] perf_stall_cnt, perf_flush_cnt;

  int checks = 0;
  int failures = 0;

  // Reference model: pending extra IF/ID flush cycles and event tallies.
  int          m_rem = 0;
  logic [31:0] m_stall = 32'd0;
  logic [31:0] m_flush = 32'd0;

  typedef struct {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       mr;
    logic       redir;
    logic       busy;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[$];

  pipeline_ctrl #(.REDIRECT_BUBBLES(B), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .ena_pc(ena_pc), .pc_sel_redirect(pc_sel_redirect), .ena_ifid(ena_ifid), .flush_ifid(flush_ifid),
    .ena_idex(ena_idex), .flush_idex(flush_idex), .ena_exmem(ena_exmem),
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic is_load_use(vec_t v);
    return v.mr && (v.rd != 5'd0) && ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
  endfunction

  function automatic logic [6:0] model_ctrl(vec_t v);
    if (!v.rst) return P_RESET;
    if (v.busy) return P_FROZEN;
    if (v.redir) return P_ENTRY;
    if (m_rem > 0) return P_BUBBLE;
    if (is_load_use(v)) return P_STALL;
    return P_RUN;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, compare outputs, then advance the model past the next edge.
  task automatic apply(input vec_t v, input logic [6:0] exp_ctrl, input string name);
    logic [31:0] es, ef;
    @(negedge clk);
    rst_n = v.rst; id_rs1 = v.rs1; id_rs2 = v.rs2; id_uses_rs1 = v.u1; id_uses_rs2 = v.u2;
    ex_rd = v.rd; ex_mem_read = v.mr; ex_redirect = v.redir; mem_busy = v.busy;
    if (!v.rst) begin
      m_rem = 0; m_stall = 32'd0; m_flush = 32'd0;
    end
    #1;
    check({name, "_ctrl"}, {25'd0, ena_pc, pc_sel_redirect, ena_ifid, flush_ifid, ena_idex, flush_idex, ena_exmem},
          {25'd0, exp_ctrl});
`ifdef PIPE_PERF_COUNTERS_EN
    es = m_stall; ef = m_flush;
`else
    es = 32'd0; ef = 32'd0;
`endif
    check({name, "_stall_cnt"}, perf_stall_cnt, es);
    check({name, "_flush_cnt"}, perf_flush_cnt, ef);
    if (v.rst) begin
      if (v.busy) m_stall = m_stall + 32'd1;
      else if (v.redir) begin m_flush = m_flush + 32'd1; m_rem = B - 1; end
      else if (m_rem > 0) m_rem = m_rem - 1;
      else if (is_load_use(v)) m_stall = m_stall + 32'd1;
    end
  endtask

  function automatic vec_t mk(logic rst, logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                              logic [4:0] rd, logic mr, logic redir, logic busy, logic [6:0] exp);
    vec_t v;
    v.rst = rst; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
    v.rd = rd; v.mr = mr; v.redir = redir; v.busy = busy; v.exp = exp;
    return v;
  endfunction

  initial begin
    vec_t v;
    rst_n = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_rd = 5'd0; ex_mem_read = 1'b0; ex_redirect = 1'b0; mem_busy = 1'b0;

    // Directed table: reset, load-use, x0, redirect, simultaneous events, freeze mid-redirect.
    vecs.push_back(mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, P_RESET));
    vecs.push_back(mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, P_RUN));
    vecs.push_back(mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, P_ENTRY));
    vecs.push_back(mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, P_RESET));
    vecs.push_back(mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, P_RUN));
    vecs.push_back(mk(1'b1, 5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, P_STALL));
    vecs.push_back(mk(1'b1, 5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, P_RUN));
    vecs.push_back(mk(1'b1, 5'd0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, P_RUN));
    vecs.push_back(mk(1'b1, 5'd2, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, P_RUN));
    vecs.push_back(mk(1'b1, 5'd7, 5'd2, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, P_STALL));
    vecs.push_back(mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, P_ENTRY));
    vecs.push_back(mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, P_BUBBLE));
    vecs.push_back(mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, P_RUN));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1, 1'b1, P_FROZEN));
    vecs.push_back(mk(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0, P_ENTRY));
    vecs.push_back(mk(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, P_BUBBLE));
    vecs.push_back(mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, P_RUN));
    vecs.push_back(mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, P_ENTRY));
    vecs.push_back(mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, P_FROZEN));
    vecs.push_back(mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, P_FROZEN));
    vecs.push_back(mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, P_BUBBLE));
    vecs.push_back(mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, P_RUN));

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], vecs[i].exp, $sformatf("vec%0d", i));

    // Hand sequence: redirect interrupted by a fresh redirect reloads the bubbles.
    apply(mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 7'd0), P_ENTRY, "rr_entry0");
    apply(mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 7'd0), P_ENTRY, "rr_entry1");
    apply(mk(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 7'd0), P_BUBBLE, "rr_bubble");
    apply(mk(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 7'd0), P_STALL, "rr_stall");

    // Randomized phase against the reference model.
    for (int i = 0; i < 400; i++) begin
      v.rst   = ($urandom_range(0, 63) != 0);
      v.rs1   = 5'($urandom_range(0, 3));
      v.rs2   = 5'($urandom_range(0, 3));
      v.u1    = 1'($urandom_range(0, 1));
      v.u2    = 1'($urandom_range(0, 1));
      v.rd    = 5'($urandom_range(0, 3));
      v.mr    = 1'($urandom_range(0, 1));
      v.redir = ($urandom_range(0, 5) == 0);
      v.busy  = ($urandom_range(0, 4) == 0);
      v.exp   = 7'd0;
      if (!v.rst) begin
        m_rem = 0;
      end
      apply(v, model_ctrl(v), $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
